pll_lock_supervisor: RTL
========================

// Module: pll_lock_supervisor
// PURPOSE
// Sequences and supervises the clocking-wizard PLL from the free-running 100 MHz board clock.
// Pulses the PLL reset and waits for lock with a timeout. Qualifies lock by stable time and
// by measuring the generated-clock period in clk100 cycles. Retries a bounded number of times.
// Releases slow_rst only when the clock is proven good. slow_rst is resynchronized by the consumer domain.
// PARAMETERS
// RST_CYCLES    16      cycles pll_rst is held high per attempt
// LOCK_TIMEOUT  100000  clk100 cycles allowed in WAIT_LOCK (1 ms)
// SETTLE_CYCLES 1024    consecutive locked cycles required before frequency check
// EXP_RATIO     10      expected clk100 cycles per generated-clock period
// RATIO_TOL     1       accepted |measured - EXP_RATIO|
// CHECK_PERIODS 8       consecutive good periods required to enter RUN
// MAX_RETRIES   3       re-attempts before FAIL (retry_cnt width 2)
// PORTS
// clk100      in   1  100 MHz system clock, sole clock
// rst         in   1  synchronous reset, active-high
// locked      in   1  PLL locked, asynchronous; 2-FF synchronized internally (locked_s)
// clk_edge    in   1  1-cycle pulse per generated-clock rising edge, already in clk100 domain
// retry_req   in   1  1-cycle pulse; restarts sequencing from FAIL only
// pll_rst     out  1  PLL reset, active-high
// slow_rst    out  1  reset request for generated-clock domain, active-high
// ready       out  1  high only in RUN
// fail        out  1  sticky failure flag
// retry_cnt   out  2  attempts consumed since last RUN entry / retry_req
// last_ratio  out  8  most recent measured period (clk100 cycles), saturates at 255
// state       out  3  0 RESET_PLL,1 WAIT_LOCK,2 SETTLE,3 CHECK_FREQ,4 RUN,5 FAIL
// BEHAVIOUR
// - rst=1 at an edge: next cycle state=RESET_PLL, pll_rst=1, slow_rst=1, ready=0, fail=0,
//   retry_cnt=0, last_ratio=0, all timers 0, sync FFs 0. Applies mid-operation in any state.
// - All outputs registered. locked_s lags locked by 2 cycles.
// - Period counter: +1 per cycle, saturates at 255. On clk_edge it is loaded into ratio and restarts at 1.
//   Edges at t and t+10 give ratio=10. The first edge after entering CHECK_FREQ only arms the counter.
// - RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with pll_rst=0.
// - WAIT_LOCK: locked_s=1 -> SETTLE. Timer reaching LOCK_TIMEOUT with no lock -> RETRY.
// - SETTLE: SETTLE_CYCLES consecutive cycles of locked_s=1 -> CHECK_FREQ.
//   locked_s=0 -> WAIT_LOCK with a fresh timeout.
// - CHECK_FREQ: on each measured edge, last_ratio<=ratio.
//   In tolerance -> good_cnt++. Out of tolerance -> RETRY. good_cnt==CHECK_PERIODS -> RUN.
//   Counter saturation (255) with no edge -> RETRY. locked_s=0 -> RETRY.
// - RUN: ready=1, slow_rst=0, retry_cnt cleared on entry. Monitoring continues with the same checks.
//   Lock loss, out-of-tolerance period, or saturation -> RETRY.
// - RETRY (decision, not a state): if retry_cnt==MAX_RETRIES -> FAIL.
//   Otherwise retry_cnt++ and -> RESET_PLL. ready drops and slow_rst rises the cycle after the decision.
// - FAIL: fail=1, pll_rst=1, slow_rst=1, ready=0. retry_req -> RESET_PLL, fail=0, retry_cnt=0.
// - slow_rst=1 in every state except RUN.
// - retry_req outside FAIL is ignored.
// - Priority when events coincide: rst > lock loss > period error > edge accept > timers.
// TESTING (sim params: LOCK_TIMEOUT=200, SETTLE_CYCLES=16, others default)
// 1 Nominal: locked rises 5 cycles after pll_rst falls; clk_edge every 10 cycles -> RUN after
//   16 settle cycles + 9 edges; ready=1, slow_rst=0, last_ratio=10, retry_cnt=0, state=4.
// 2 Timeout: locked held 0 -> 4 pll_rst pulses of 16 cycles, each after a 200-cycle wait;
//   then fail=1, state=5. retry_req -> state=0, fail=0, retry_cnt=0.
// 3 Ratio: edges every 11 -> RUN, last_ratio=11. Edges every 12 -> last_ratio=12, RETRY, retry_cnt=1.
// 4 Lock loss in RUN: locked 1->0 -> within 4 cycles state=0, ready=0, slow_rst=1, retry_cnt=1.
// 5 Edge loss in RUN: clk_edge stops -> 255 cycles later RETRY, last_ratio unchanged.
//   Locked drop coincident with edge -> lock-loss path taken.
// 6 rst pulse in CHECK_FREQ and in FAIL -> next cycle all outputs at reset values, state=0.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// PLL supervisor status/control bundle.
// Groups the PLL-facing inputs and the supervisor status outputs so that the
// supervisor and its environment share one connection.
//   locked     : PLL locked, asynchronous to clk100
//   clk_edge   : 1-cycle pulse per generated-clock rising edge (clk100 domain)
//   retry_req  : 1-cycle pulse, restarts sequencing from FAIL
//   pll_rst    : PLL reset, active-high
//   slow_rst   : generated-clock domain reset request, active-high
//   ready      : clock proven good (RUN)
//   fail       : sticky failure flag
//   retry_cnt  : attempts consumed since last RUN entry / retry_req
//   last_ratio : most recent measured period in clk100 cycles
//   state      : supervisor state code
// modport master = supervisor side, slave = PLL / environment side.
interface pll_lock_supervisor_if;
  logic       locked;
  logic       clk_edge;
  logic       retry_req;
  logic       pll_rst;
  logic       slow_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] last_ratio;
  logic [2:0] state;

  modport master (
    input  locked, clk_edge, retry_req,
    output pll_rst, slow_rst, ready, fail, retry_cnt, last_ratio, state
  );

  modport slave (
    output locked, clk_edge, retry_req,
    input  pll_rst, slow_rst, ready, fail, retry_cnt, last_ratio, state
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor.
// Pulses the PLL reset, waits for lock with a timeout, qualifies lock by a
// stable-lock interval and by measuring the generated-clock period in clk100
// cycles, and retries a bounded number of times before declaring failure.
// slow_rst is released only while the clock is proven good.
//   clk100 : 100 MHz system clock, sole clock
//   rst    : synchronous reset, active-high
//   bus    : status/control bundle (master side), see pll_lock_supervisor_if
//
// state          | meaning
// ST_RESET_PLL 0 | pll_rst held high for RST_CYCLES
// ST_WAIT_LOCK 1 | waiting for locked_s, bounded by LOCK_TIMEOUT
// ST_SETTLE    2 | locked_s must stay high for SETTLE_CYCLES
// ST_CHECK_FREQ3 | measuring periods until CHECK_PERIODS good ones
// ST_RUN       4 | clock good, slow_rst released, monitoring continues
// ST_FAIL      5 | retries exhausted, waits for retry_req
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int EXP_RATIO     = 10,
  parameter int RATIO_TOL     = 1,
  parameter int CHECK_PERIODS = 8,
  parameter int MAX_RETRIES   = 3
) (
  input logic                   clk100,
  input logic                   rst,
  pll_lock_supervisor_if.master bus
);

  typedef enum logic [2:0] {
    ST_RESET_PLL  = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_CHECK_FREQ = 3'd3,
    ST_RUN        = 3'd4,
    ST_FAIL       = 3'd5
  } state_t;

  localparam int TMAX0 = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int TMAX  = (TMAX0 > RST_CYCLES) ? TMAX0 : RST_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int GW    = $clog2(CHECK_PERIODS + 1);
  localparam logic [7:0] RATIO_LO = 8'(EXP_RATIO - RATIO_TOL);
  localparam logic [7:0] RATIO_HI = 8'(EXP_RATIO + RATIO_TOL);

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [7:0]      per_cnt, per_nxt;
  logic            armed, armed_nxt;
  logic [GW-1:0]   good_cnt, good_nxt;
  logic [1:0]      retry_cnt, retry_nxt;
  logic [7:0]      last_ratio, ratio_nxt;
  logic            locked_m, locked_s;
  logic            pll_rst, slow_rst, ready, fail;
  logic            do_retry;
  logic            monitoring;
  logic            in_tol;

  assign monitoring = (state == ST_CHECK_FREQ) || (state == ST_RUN);
  assign in_tol     = (per_cnt >= RATIO_LO) && (per_cnt <= RATIO_HI);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    per_nxt   = per_cnt;
    armed_nxt = armed;
    good_nxt  = good_cnt;
    retry_nxt = retry_cnt;
    ratio_nxt = last_ratio;
    do_retry  = 1'b0;

    // Period counter only runs while measuring so every CHECK_FREQ entry starts from 0.
    if (monitoring) begin
      if (bus.clk_edge)          per_nxt = 8'd1;
      else if (per_cnt != 8'hFF) per_nxt = per_cnt + 8'd1;
    end else begin
      per_nxt = '0;
    end

    case (state)
      ST_RESET_PLL: begin
        if (timer == TW'(RST_CYCLES - 1)) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s)                            state_nxt = ST_SETTLE;
        else if (timer == TW'(LOCK_TIMEOUT - 1)) do_retry  = 1'b1;
      end
      ST_SETTLE: begin
        if (!locked_s)                            state_nxt = ST_WAIT_LOCK;
        else if (timer == TW'(SETTLE_CYCLES - 1)) state_nxt = ST_CHECK_FREQ;
      end
      ST_CHECK_FREQ, ST_RUN: begin
        // Priority: lock loss, period error, edge accept, saturation.
        if (!locked_s) begin
          do_retry = 1'b1;
        end else if (bus.clk_edge && armed) begin
          ratio_nxt = per_cnt;
          if (!in_tol) begin
            do_retry = 1'b1;
          end else if (state == ST_CHECK_FREQ) begin
            if (good_cnt == GW'(CHECK_PERIODS - 1)) begin
              state_nxt = ST_RUN;
              retry_nxt = '0;
            end else begin
              good_nxt = good_cnt + GW'(1);
            end
          end
        end else if (bus.clk_edge) begin
          armed_nxt = 1'b1;
        end else if (per_cnt == 8'hFF) begin
          do_retry = 1'b1;
        end
      end
      ST_FAIL: begin
        if (bus.retry_req) begin
          state_nxt = ST_RESET_PLL;
          retry_nxt = '0;
        end
      end
      default: state_nxt = ST_RESET_PLL;
    endcase

    if (do_retry) begin
      if (retry_cnt == 2'(MAX_RETRIES)) begin
        state_nxt = ST_FAIL;
      end else begin
        retry_nxt = retry_cnt + 2'd1;
        state_nxt = ST_RESET_PLL;
      end
    end

    // Shared interval timer: restarts on every state change.
    if (state_nxt != state) begin
      timer_nxt = '0;
    end else if ((state == ST_RESET_PLL) || (state == ST_WAIT_LOCK) || (state == ST_SETTLE)) begin
      timer_nxt = timer + TW'(1);
    end

    if ((state_nxt != ST_CHECK_FREQ) && (state_nxt != ST_RUN)) begin
      armed_nxt = 1'b0;
      good_nxt  = '0;
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state      <= ST_RESET_PLL;
      timer      <= '0;
      per_cnt    <= '0;
      armed      <= 1'b0;
      good_cnt   <= '0;
      retry_cnt  <= '0;
      last_ratio <= '0;
      locked_m   <= 1'b0;
      locked_s   <= 1'b0;
      pll_rst    <= 1'b1;
      slow_rst   <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      locked_m   <= bus.locked;
      locked_s   <= locked_m;
      state      <= state_nxt;
      timer      <= timer_nxt;
      per_cnt    <= per_nxt;
      armed      <= armed_nxt;
      good_cnt   <= good_nxt;
      retry_cnt  <= retry_nxt;
      last_ratio <= ratio_nxt;
      pll_rst    <= (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAIL);
      slow_rst   <= (state_nxt != ST_RUN);
      ready      <= (state_nxt == ST_RUN);
      fail       <= (state_nxt == ST_FAIL);
    end
  end

  assign bus.pll_rst    = pll_rst;
  assign bus.slow_rst   = slow_rst;
  assign bus.ready      = ready;
  assign bus.fail       = fail;
  assign bus.retry_cnt  = retry_cnt;
  assign bus.last_ratio = last_ratio;
  assign bus.state      = state;

endmodule
